// File: rtl/cdm16_bus_arbiter.sv
// Shares the cdm16 memory bus between the CPU (default owner) and two DMA masters.
// Holds the CPU, grants one DMA master round-robin with a bounded burst, then hands the bus back.
module cdm16_bus_arbiter #(
  parameter int HOLD_SETTLE = 1,
  parameter int MAX_BURST   = 8,
  parameter int CPU_MIN     = 2
) (
  input  logic        input_clock,
  input  logic        reset,
  input  logic        cpu_mem,
  input  logic        cpu_read,
  input  logic        cpu_word,
  input  logic        cpu_data,
  input  logic [15:0] cpu_address,
  input  logic [15:0] cpu_data_out,
  output logic [15:0] cpu_data_in,
  output logic        hold,
  input  logic        dma0_req,
  output logic        dma0_grant,
  input  logic        dma0_mem,
  input  logic        dma0_read,
  input  logic        dma0_word,
  input  logic [15:0] dma0_address,
  input  logic [15:0] dma0_data_out,
  input  logic        dma1_req,
  output logic        dma1_grant,
  input  logic        dma1_mem,
  input  logic        dma1_read,
  input  logic        dma1_word,
  input  logic [15:0] dma1_address,
  input  logic [15:0] dma1_data_out,
  output logic [15:0] dma_data_in,
  output logic        dma_misalign,
  output logic        mem_mem,
  output logic        mem_read,
  output logic        mem_word,
  output logic        mem_data,
  output logic [15:0] mem_address,
  output logic [15:0] mem_data_out,
  input  logic [15:0] mem_data_in,
  output logic [1:0]  owner
);

  typedef enum logic [1:0] {CPU_OWN, HOLD_REQ, DMA_OWN, RELEASE} state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(HOLD_SETTLE - 1);
  localparam logic [7:0] BURST_LAST  = 8'(MAX_BURST - 1);
  localparam logic [7:0] CPUMIN_LOAD = 8'(CPU_MIN - 1);

  state_t      state_q, state_d;
  logic [7:0]  settle_q, settle_d;
  logic [7:0]  burst_q, burst_d;
  logic [7:0]  cpumin_q, cpumin_d;
  logic        ptr_q, ptr_d;
  logic        gnt_q, gnt_d;
  logic        misalign_q, misalign_d;

  logic        any_req, ptr_req, gnt_req;
  logic        sel_mem, sel_read, sel_word;
  logic [15:0] sel_addr, sel_dout;

  assign any_req  = dma0_req | dma1_req;
  assign ptr_req  = ptr_q ? dma1_req : dma0_req;
  assign gnt_req  = gnt_q ? dma1_req : dma0_req;
  assign sel_mem  = gnt_q ? dma1_mem : dma0_mem;
  assign sel_read = gnt_q ? dma1_read : dma0_read;
  assign sel_word = gnt_q ? dma1_word : dma0_word;
  assign sel_addr = gnt_q ? dma1_address : dma0_address;
  assign sel_dout = gnt_q ? dma1_data_out : dma0_data_out;

  always_ff @(posedge input_clock) begin
    if (reset) begin
      state_q    <= CPU_OWN;
      settle_q   <= 8'd0;
      burst_q    <= 8'd0;
      cpumin_q   <= 8'd0;
      ptr_q      <= 1'b0;
      gnt_q      <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      burst_q    <= burst_d;
      cpumin_q   <= cpumin_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      misalign_q <= misalign_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    burst_d  = burst_q;
    cpumin_d = cpumin_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    case (state_q)
      CPU_OWN: begin
        if (cpumin_q != 8'd0) cpumin_d = cpumin_q - 8'd1;
        if (any_req && cpumin_q == 8'd0) begin
          state_d  = HOLD_REQ;
          settle_d = 8'd0;
        end
      end
      HOLD_REQ: begin
        if (!any_req) begin
          state_d = RELEASE;
        end else if (settle_q == SETTLE_LAST) begin
          state_d = DMA_OWN;
          burst_d = 8'd0;
          gnt_d   = ptr_req ? ptr_q : ~ptr_q;
        end else begin
          settle_d = settle_q + 8'd1;
        end
      end
      DMA_OWN: begin
        burst_d = burst_q + 8'd1;
        if (!gnt_req || burst_q == BURST_LAST) begin
          state_d = RELEASE;
          ptr_d   = ~gnt_q;
        end
      end
      default: begin
        state_d  = CPU_OWN;
        cpumin_d = CPUMIN_LOAD;
      end
    endcase
  end

  // Bus mux follows the registered state; turnaround states drive an idle bus.
  always_comb begin
    mem_mem      = 1'b0;
    mem_read     = 1'b0;
    mem_word     = 1'b0;
    mem_data     = 1'b0;
    mem_address  = 16'h0;
    mem_data_out = 16'h0;
    cpu_data_in  = 16'h0;
    dma_data_in  = 16'h0;
    owner        = 2'd3;
    misalign_d   = 1'b0;
    case (state_q)
      CPU_OWN: begin
        mem_mem      = cpu_mem;
        mem_read     = cpu_read;
        mem_word     = cpu_word;
        mem_data     = cpu_data;
        mem_address  = cpu_address;
        mem_data_out = cpu_data_out;
        cpu_data_in  = mem_data_in;
        owner        = 2'd0;
      end
      DMA_OWN: begin
        mem_mem      = sel_mem;
        mem_read     = sel_read;
        mem_word     = sel_word & ~sel_addr[0];
        mem_address  = sel_addr;
        mem_data_out = sel_dout;
        dma_data_in  = mem_data_in;
        owner        = gnt_q ? 2'd2 : 2'd1;
        misalign_d   = sel_mem & sel_word & sel_addr[0];
      end
      default: ;
    endcase
  end

  assign hold         = (state_q != CPU_OWN);
  assign dma0_grant   = (state_q == DMA_OWN) && !gnt_q;
  assign dma1_grant   = (state_q == DMA_OWN) && gnt_q;
  assign dma_misalign = misalign_q;

endmodule

// File: tb/tb_cdm16_bus_arbiter.sv
// Directed bench for cdm16_bus_arbiter: cycle tables plus hand-written tenure sequences.
module tb_cdm16_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_mem, cpu_read, cpu_word, cpu_data;
  logic [15:0] cpu_address, cpu_data_out, cpu_data_in;
  logic        hold;
  logic        dma0_req, dma0_grant, dma0_mem, dma0_read, dma0_word;
  logic [15:0] dma0_address, dma0_data_out;
  logic        dma1_req, dma1_grant, dma1_mem, dma1_read, dma1_word;
  logic [15:0] dma1_address, dma1_data_out;
  logic [15:0] dma_data_in;
  logic        dma_misalign;
  logic        mem_mem, mem_read, mem_word, mem_data;
  logic [15:0] mem_address, mem_data_out, mem_data_in;
  logic [1:0]  owner;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       r0;
    logic       r1;
    logic       hold;
    logic       g0;
    logic       g1;
    logic [1:0] owner;
  } vec_t;

  vec_t tbl[12];
  int   exp_q[$];

  always #5 clk = ~clk;

  cdm16_bus_arbiter dut (
    .input_clock(clk), .reset(reset),
    .cpu_mem(cpu_mem), .cpu_read(cpu_read), .cpu_word(cpu_word), .cpu_data(cpu_data),
    .cpu_address(cpu_address), .cpu_data_out(cpu_data_out), .cpu_data_in(cpu_data_in),
    .hold(hold),
    .dma0_req(dma0_req), .dma0_grant(dma0_grant), .dma0_mem(dma0_mem), .dma0_read(dma0_read),
    .dma0_word(dma0_word), .dma0_address(dma0_address), .dma0_data_out(dma0_data_out),
    .dma1_req(dma1_req), .dma1_grant(dma1_grant), .dma1_mem(dma1_mem), .dma1_read(dma1_read),
    .dma1_word(dma1_word), .dma1_address(dma1_address), .dma1_data_out(dma1_data_out),
    .dma_data_in(dma_data_in), .dma_misalign(dma_misalign),
    .mem_mem(mem_mem), .mem_read(mem_read), .mem_word(mem_word), .mem_data(mem_data),
    .mem_address(mem_address), .mem_data_out(mem_data_out), .mem_data_in(mem_data_in),
    .owner(owner)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    cpu_mem = 0; cpu_read = 0; cpu_word = 0; cpu_data = 0;
    cpu_address = 16'h0; cpu_data_out = 16'h0;
    dma0_req = 0; dma0_mem = 0; dma0_read = 0; dma0_word = 0;
    dma0_address = 16'h0; dma0_data_out = 16'h0;
    dma1_req = 0; dma1_mem = 0; dma1_read = 0; dma1_word = 0;
    dma1_address = 16'h0; dma1_data_out = 16'h0;
    mem_data_in = 16'h0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input int which, output bit ok);
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      @(negedge clk);
      if ((which == 0 && dma0_grant) || (which == 1 && dma1_grant)) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("grant_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    bit ok;
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};

    // Reset state and CPU pass-through
    do_reset();
    chk("rst_hold", 32'(hold), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_g0", 32'(dma0_grant), 32'd0);
    chk("rst_g1", 32'(dma1_grant), 32'd0);
    chk("rst_misalign", 32'(dma_misalign), 32'd0);
    next_cycle();
    cpu_mem = 1; cpu_read = 1; cpu_word = 1; cpu_address = 16'h1234; mem_data_in = 16'hBEEF;
    @(negedge clk);
    chk("cpu_addr", 32'(mem_address), 32'h1234);
    chk("cpu_mem", 32'(mem_mem), 32'd1);
    chk("cpu_read", 32'(mem_read), 32'd1);
    chk("cpu_word", 32'(mem_word), 32'd1);
    chk("cpu_rdata", 32'(cpu_data_in), 32'hBEEF);
    chk("cpu_dma_rdata", 32'(dma_data_in), 32'h0);
    mem_data_in = 16'h5A5A;
    #1;
    chk("cpu_rdata_track", 32'(cpu_data_in), 32'h5A5A);
    next_cycle();
    clear_inputs();
    @(negedge clk);

    // Single tenure, then a request that drops during HOLD_REQ
    for (int i = 0; i < 12; i++) begin
      next_cycle();
      dma0_req = tbl[i].r0;
      dma1_req = tbl[i].r1;
      @(negedge clk);
      chk($sformatf("tbl%0d_hold", i), 32'(hold), 32'(tbl[i].hold));
      chk($sformatf("tbl%0d_g0", i), 32'(dma0_grant), 32'(tbl[i].g0));
      chk($sformatf("tbl%0d_g1", i), 32'(dma1_grant), 32'(tbl[i].g1));
      chk($sformatf("tbl%0d_owner", i), 32'(owner), 32'(tbl[i].owner));
    end

    // Continuous requests: alternating full bursts with CPU gaps
    do_reset();
    exp_q.push_back(0);
    exp_q.push_back(3);
    repeat (8) exp_q.push_back(1);
    exp_q.push_back(3); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(3);
    repeat (8) exp_q.push_back(2);
    exp_q.push_back(3); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(3);
    repeat (8) exp_q.push_back(1);
    exp_q.push_back(3);
    exp_q.push_back(0);
    for (int i = 0; i < exp_q.size(); i++) begin
      next_cycle();
      if (i == 0) begin
        cpu_mem = 1; cpu_read = 1; cpu_address = 16'h1234;
        dma0_mem = 1; dma0_read = 1; dma0_address = 16'h2000;
        dma1_mem = 1; dma1_read = 1; dma1_address = 16'h3000;
        dma0_req = 1; dma1_req = 1;
      end
      @(negedge clk);
      chk($sformatf("rr%0d_owner", i), 32'(owner), 32'(exp_q[i]));
      chk($sformatf("rr%0d_g0", i), 32'(dma0_grant), 32'(exp_q[i] == 1));
      chk($sformatf("rr%0d_g1", i), 32'(dma1_grant), 32'(exp_q[i] == 2));
      chk($sformatf("rr%0d_hold", i), 32'(hold), 32'(exp_q[i] != 0));
      chk($sformatf("rr%0d_mem", i), 32'(mem_mem), 32'(exp_q[i] != 3));
      chk($sformatf("rr%0d_addr", i), 32'(mem_address),
          exp_q[i] == 0 ? 32'h1234 : exp_q[i] == 1 ? 32'h2000 : exp_q[i] == 2 ? 32'h3000 : 32'h0);
    end

    // Misaligned dma1 word write, then an aligned one
    do_reset();
    next_cycle();
    dma1_req = 1;
    wait_grant(1, ok);
    if (ok) begin
      next_cycle();
      dma1_mem = 1; dma1_word = 1; dma1_address = 16'h0101; dma1_data_out = 16'hABCD;
      @(negedge clk);
      chk("mis_mem_word", 32'(mem_word), 32'd0);
      chk("mis_mem_mem", 32'(mem_mem), 32'd1);
      chk("mis_mem_read", 32'(mem_read), 32'd0);
      chk("mis_addr", 32'(mem_address), 32'h0101);
      chk("mis_wdata", 32'(mem_data_out), 32'hABCD);
      chk("mis_pulse_early", 32'(dma_misalign), 32'd0);
      next_cycle();
      dma1_address = 16'h0100;
      @(negedge clk);
      chk("mis_pulse", 32'(dma_misalign), 32'd1);
      chk("al_mem_word", 32'(mem_word), 32'd1);
      next_cycle();
      dma1_mem = 0; dma1_word = 0;
      @(negedge clk);
      chk("mis_pulse_once", 32'(dma_misalign), 32'd0);
    end
    dma1_req = 0;

    // Reset asserted during the third granted cycle
    do_reset();
    next_cycle();
    dma0_req = 1;
    wait_grant(0, ok);
    if (ok) begin
      next_cycle();
      next_cycle();
      reset = 1'b1;
      @(negedge clk);
      chk("rst3_g0_before", 32'(dma0_grant), 32'd1);
      next_cycle();
      reset = 1'b0;
      dma0_req = 0;
      @(negedge clk);
      chk("rst3_g0", 32'(dma0_grant), 32'd0);
      chk("rst3_g1", 32'(dma1_grant), 32'd0);
      chk("rst3_hold", 32'(hold), 32'd0);
      chk("rst3_owner", 32'(owner), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
